// File: rtl/dmem_responder.sv
// Data memory with a processor port that always wins, plus a host access
// port and a full-memory zero-fill engine that only use idle processor cycles.
module dmem_responder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 64
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [0:ADDR_W-1] Mem_Addr,
  input  logic [0:DATA_W-1] Data_In,
  output logic [0:DATA_W-1] Data_Out,
  input  logic              DmemEn,
  input  logic              DmemWrEn,
  input  logic              Host_Req,
  input  logic              Host_Wr,
  input  logic [0:ADDR_W-1] Host_Addr,
  input  logic [0:DATA_W-1] Host_Wdata,
  output logic              Host_Ack,
  output logic [0:DATA_W-1] Host_Rdata,
  input  logic              Clr_Start,
  output logic              Clr_Done
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    StIdle,
    StHost,
    StClear
  } state_e;

  state_e            state_q, state_d;
  logic [0:ADDR_W-1] cnt_q, cnt_d;

  logic              host_wr_q;
  logic [0:ADDR_W-1] host_addr_q;
  logic [0:DATA_W-1] host_wdata_q;

  logic [0:DATA_W-1] mem [Depth];

  logic              latch_en;
  logic              host_rd;
  logic              ack_d;
  logic              done_d;
  logic              mem_we;
  logic [0:ADDR_W-1] mem_waddr;
  logic [0:DATA_W-1] mem_wdata;

  // Next-state and single write-port arbitration: the processor owns every
  // cycle it asserts DmemEn; host and clear work only on the remaining cycles.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_en  = 1'b0;
    host_rd   = 1'b0;
    ack_d     = 1'b0;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = Mem_Addr;
    mem_wdata = Data_In;

    if (DmemEn) begin
      mem_we = DmemWrEn;
    end else begin
      case (state_q)
        StIdle: begin
          if (Clr_Start) begin
            state_d = StClear;
            cnt_d   = '0;
          end else if (Host_Req) begin
            state_d  = StHost;
            latch_en = 1'b1;
          end
        end
        StHost: begin
          if (host_wr_q) begin
            mem_we    = 1'b1;
            mem_waddr = host_addr_q;
            mem_wdata = host_wdata_q;
          end else begin
            host_rd = 1'b1;
          end
          ack_d   = 1'b1;
          state_d = StIdle;
        end
        StClear: begin
          mem_we    = 1'b1;
          mem_waddr = cnt_q;
          mem_wdata = '0;
          if (cnt_q == '1) begin
            done_d  = 1'b1;
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      Data_Out   <= '0;
      Host_Rdata <= '0;
      Host_Ack   <= 1'b0;
      Clr_Done   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      Host_Ack <= ack_d;
      Clr_Done <= done_d;
      if (DmemEn && !DmemWrEn) begin
        Data_Out <= mem[Mem_Addr];
      end
      if (host_rd) begin
        Host_Rdata <= mem[host_addr_q];
      end
    end
  end

  // Host request capture; the host may drop its request lines after Ack.
  always_ff @(posedge Clock) begin
    if (latch_en) begin
      host_wr_q    <= Host_Wr;
      host_addr_q  <= Host_Addr;
      host_wdata_q <= Host_Wdata;
    end
  end

  // Storage; not reset, and no FSM-driven write lands on a reset edge.
  always_ff @(posedge Clock) begin
    if (mem_we && !Reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule
